cpu_branch_predictor: RTL and testbench



---
 rtl/cpu_branch_predictor.sv | 76 +++++++
 tb/tb_cpu_branch_predictor.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped 2-bit saturating counters plus a
// tagged BTB, with a combinational lookup and training from resolved branches.
module cpu_branch_predictor #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_f,
  output logic        pred_taken_f,
  output logic [31:0] pred_target_f,
  input  logic        resolve_valid_e,
  input  logic [31:0] resolve_pc_e,
  input  logic        resolve_taken_e,
  input  logic [31:0] resolve_target_e,
  input  logic        resolve_pred_taken_e,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int TAG_BITS = 30 - INDEX_BITS;
  localparam int DEPTH    = 1 << INDEX_BITS;

  logic [1:0]          ctr        [DEPTH];
  logic [DEPTH-1:0]    valid;
  logic [TAG_BITS-1:0] tag_mem    [DEPTH];
  logic [31:0]         target_mem [DEPTH];

  logic [INDEX_BITS-1:0] idx_f, idx_e;
  logic [TAG_BITS-1:0]   tag_f, tag_e;
  logic                  hit_f;
  logic                  unused_pc_bits;

  assign idx_f = pc_f[INDEX_BITS+1:2];
  assign tag_f = pc_f[31:INDEX_BITS+2];
  assign idx_e = resolve_pc_e[INDEX_BITS+1:2];
  assign tag_e = resolve_pc_e[31:INDEX_BITS+2];

  // PCs are word aligned, so the low two bits carry no information.
  assign unused_pc_bits = ^{pc_f[1:0], resolve_pc_e[1:0]};

  // Lookup reads the registered arrays only, so a same-cycle update is not seen.
  assign hit_f         = valid[idx_f] && (tag_mem[idx_f] == tag_f);
  assign pred_taken_f  = hit_f && ctr[idx_f][1];
  assign pred_target_f = pred_taken_f ? target_mem[idx_f] : 32'd0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ctr[i] <= 2'b01;
      valid            <= '0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (resolve_valid_e) begin
      if (resolve_taken_e) begin
        if (ctr[idx_e] != 2'b11) ctr[idx_e] <= ctr[idx_e] + 2'b01;
        valid[idx_e] <= 1'b1;
      end else if (ctr[idx_e] != 2'b00) begin
        ctr[idx_e] <= ctr[idx_e] - 2'b01;
      end
      branch_count <= branch_count + 32'd1;
      if (resolve_taken_e != resolve_pred_taken_e)
        mispredict_count <= mispredict_count + 32'd1;
    end
  end

  // NOTE: tag and target storage is deliberately left unreset; valid gates
  // every use of it, which lets this map onto plain RAM.
  always_ff @(posedge clk) begin
    if (!rst && resolve_valid_e && resolve_taken_e) begin
      tag_mem[idx_e]    <= tag_e;
      target_mem[idx_e] <= resolve_target_e;
    end
  end

endmodule

// File: tb/tb_cpu_branch_predictor.sv
// Self-checking bench for cpu_branch_predictor: directed test-plan steps followed
// by randomized traffic compared against a behavioural table model.
module tb_cpu_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_f;
  logic        pred_taken_f;
  logic [31:0] pred_target_f;
  logic        resolve_valid_e;
  logic [31:0] resolve_pc_e;
  logic        resolve_taken_e;
  logic [31:0] resolve_target_e;
  logic        resolve_pred_taken_e;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int errors = 0;
  int checks = 0;

  // Reference model: plain integer counters clamped to 0..3, per-index BTB.
  int          m_ctr    [64];
  bit          m_valid  [64];
  int unsigned m_tag    [64];
  int unsigned m_target [64];
  int unsigned m_branches;
  int unsigned m_mispredicts;

  cpu_branch_predictor #(.INDEX_BITS(6)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .pc_f                 (pc_f),
    .pred_taken_f         (pred_taken_f),
    .pred_target_f        (pred_target_f),
    .resolve_valid_e      (resolve_valid_e),
    .resolve_pc_e         (resolve_pc_e),
    .resolve_taken_e      (resolve_taken_e),
    .resolve_target_e     (resolve_target_e),
    .resolve_pred_taken_e (resolve_pred_taken_e),
    .branch_count         (branch_count),
    .mispredict_count     (mispredict_count)
  );

  always #5 clk = ~clk;

  function automatic int idx_of(input int unsigned pc);
    return (pc / 4) % 64;
  endfunction

  function automatic int unsigned tag_of(input int unsigned pc);
    return pc / 256;
  endfunction

  function automatic bit model_taken(input int unsigned pc);
    int i;
    i = idx_of(pc);
    return m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
  endfunction

  function automatic int unsigned model_target(input int unsigned pc);
    return model_taken(pc) ? m_target[idx_of(pc)] : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_ctr[i]   = 1;
      m_valid[i] = 1'b0;
    end
    m_branches    = 0;
    m_mispredicts = 0;
  endtask

  task automatic model_train(input int unsigned pc, input bit taken,
                             input int unsigned target, input bit pred);
    int i;
    i = idx_of(pc);
    if (taken) begin
      m_ctr[i]    = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
      m_valid[i]  = 1'b1;
      m_tag[i]    = tag_of(pc);
      m_target[i] = target;
    end else begin
      m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
    end
    m_branches++;
    if (taken != pred) m_mispredicts++;
  endtask

  task automatic check(input string name, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", name, observed, expected);
    end
  endtask

  // Called away from the rising edge; checks the combinational prediction.
  task automatic lookup(input string name, input logic [31:0] pc,
                        input logic exp_taken, input logic [31:0] exp_target);
    pc_f = pc;
    #1;
    check({name, "_taken"}, {31'd0, pred_taken_f}, {31'd0, exp_taken});
    check({name, "_target"}, pred_target_f, exp_target);
  endtask

  task automatic check_counts(input string name);
    check({name, "_branches"}, branch_count, m_branches);
    check({name, "_mispredicts"}, mispredict_count, m_mispredicts);
  endtask

  // Drives one resolve pulse starting at a falling edge.
  task automatic resolve(input logic [31:0] pc, input logic taken,
                         input logic [31:0] target, input logic pred);
    resolve_valid_e      = 1'b1;
    resolve_pc_e         = pc;
    resolve_taken_e      = taken;
    resolve_target_e     = target;
    resolve_pred_taken_e = pred;
    @(posedge clk);
    model_train(pc, taken, target, pred);
    @(negedge clk);
    resolve_valid_e = 1'b0;
  endtask

  initial begin
    logic [31:0] rpc, rtgt;
    logic        rtaken, rpred, rvalid;

    rst = 1'b1;
    pc_f = 32'd0;
    resolve_valid_e = 1'b0;
    resolve_pc_e = 32'd0;
    resolve_taken_e = 1'b0;
    resolve_target_e = 32'd0;
    resolve_pred_taken_e = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Reset default
    lookup("reset_pred", 32'h100, 1'b0, 32'h0);
    check_counts("reset");

    // Single training: weak-NT -> weak-T, first taken is a mispredict
    resolve(32'h100, 1'b1, 32'h80, 1'b0);
    lookup("train1", 32'h100, 1'b1, 32'h80);
    check("train1_branches", branch_count, 32'd1);
    check("train1_mispredicts", mispredict_count, 32'd1);

    // Hysteresis: saturate at strong-T, one not-taken keeps predicting taken
    resolve(32'h100, 1'b1, 32'h80, 1'b1);
    resolve(32'h100, 1'b1, 32'h80, 1'b1);
    resolve(32'h100, 1'b0, 32'h0, 1'b1);
    lookup("hyst_one_nt", 32'h100, 1'b1, 32'h80);
    resolve(32'h100, 1'b0, 32'h0, 1'b1);
    lookup("hyst_two_nt", 32'h100, 1'b0, 32'h0);
    // Valid survived: a single taken lifts weak-NT back to weak-T and hits.
    resolve(32'h100, 1'b1, 32'h80, 1'b0);
    lookup("hyst_rehit", 32'h100, 1'b1, 32'h80);
    check_counts("hyst");

    // Aliasing: 0x200 shares index 0 with a different tag
    lookup("alias_miss", 32'h200, 1'b0, 32'h0);
    resolve(32'h200, 1'b1, 32'h40, 1'b0);
    lookup("alias_new", 32'h200, 1'b1, 32'h40);
    lookup("alias_old", 32'h100, 1'b0, 32'h0);

    // Same-cycle hazard on a fresh index: lookup sees pre-update state
    pc_f                 = 32'h104;
    resolve_valid_e      = 1'b1;
    resolve_pc_e         = 32'h104;
    resolve_taken_e      = 1'b1;
    resolve_target_e     = 32'h300;
    resolve_pred_taken_e = 1'b0;
    #1;
    check("hazard_same_cycle", {31'd0, pred_taken_f}, 32'd0);
    @(posedge clk);
    model_train(32'h104, 1'b1, 32'h300, 1'b0);
    @(negedge clk);
    resolve_valid_e = 1'b0;
    lookup("hazard_next", 32'h104, 1'b1, 32'h300);
    check_counts("hazard");

    // Reset coincident with a resolve: the resolve is dropped
    rst = 1'b1;
    resolve_valid_e = 1'b1;
    resolve_pc_e = 32'h108;
    resolve_taken_e = 1'b1;
    resolve_target_e = 32'h500;
    resolve_pred_taken_e = 1'b0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    resolve_valid_e = 1'b0;
    lookup("rst_mid_a", 32'h200, 1'b0, 32'h0);
    lookup("rst_mid_b", 32'h104, 1'b0, 32'h0);
    lookup("rst_mid_c", 32'h108, 1'b0, 32'h0);
    check_counts("rst_mid");
    // Counters back at weak-NT: one taken must be enough to predict taken.
    resolve(32'h108, 1'b1, 32'h500, 1'b0);
    lookup("rst_ctr_weak", 32'h108, 1'b1, 32'h500);

    // Randomized traffic over 8 indices x 4 tags to exercise aliasing
    for (int n = 0; n < 400; n++) begin
      pc_f = {22'd0, 2'($urandom_range(0, 3)), 3'd0, 3'($urandom_range(0, 7)), 2'b00};
      #1;
      check("rand_taken", {31'd0, pred_taken_f}, {31'd0, model_taken(pc_f)});
      check("rand_target", pred_target_f, model_target(pc_f));
      rvalid = 1'($urandom_range(0, 1));
      rpc    = {22'd0, 2'($urandom_range(0, 3)), 3'd0, 3'($urandom_range(0, 7)), 2'b00};
      rtaken = 1'($urandom_range(0, 2) != 0);
      rtgt   = {$urandom} & 32'hFFFF_FFFC;
      rpred  = ($urandom_range(0, 3) == 0) ? ~model_taken(rpc) : model_taken(rpc);
      resolve_valid_e      = rvalid;
      resolve_pc_e         = rpc;
      resolve_taken_e      = rtaken;
      resolve_target_e     = rtgt;
      resolve_pred_taken_e = rpred;
      @(posedge clk);
      if (rvalid) model_train(rpc, rtaken, rtgt, rpred);
      @(negedge clk);
      resolve_valid_e = 1'b0;
      check_counts("rand");
    end

    // Wrap: preload branch_count to all ones, one resolve wraps it to 0
    force dut.branch_count = 32'hFFFF_FFFF;
    #1;
    release dut.branch_count;
    @(negedge clk);
    m_branches = 32'hFFFF_FFFF;
    resolve(32'h10C, 1'b0, 32'h0, 1'b0);
    check("wrap_branches", branch_count, 32'd0);
    check("wrap_model", branch_count, m_branches);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
